if_stage: RTL and testbench

- Instruction-fetch stage of the mips32 pipeline.
- Owns the program counter and runs a single-outstanding req/ack handshake with instruction memory.
- Produces the PC+4 / instruction / valid triple that the IF/ID pipeline register latches.
- Honours stall from the hazard unit and redirect (branch/jump/flush) from later stages.

---
 rtl/mips_pkg.sv | 19 +
 rtl/if_fetch_buffer.sv | 30 +++
 rtl/if_stage.sv | 98 +++++++++
 tb/tb_if_stage.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared mips32 pipeline definitions: fetch FSM states, NOP, PC step and the
// fetch buffer entry layout.
package mips_pkg;
  localparam logic [31:0] NOP          = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] PC_STEP      = 32'd4;

  typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // Modulo-2^32 sequential fetch address; FFFF_FFFC wraps to 0.
  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction
endpackage

// File: rtl/if_fetch_buffer.sv
// One-entry holding register for an instruction fetched while decode is stalled.
module if_fetch_buffer
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] dinInst,
  input  logic [31:0] dinPc,
  output logic [31:0] doutInst,
  output logic [31:0] doutPc,
  output logic        full
);
  fetch_entry_t entry;

  // Clear wins over load so a redirect can never leave a stale entry behind.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      entry <= '{pc: 32'h0, inst: NOP};
      full  <= 1'b0;
    end else if (load) begin
      entry <= '{pc: dinPc, inst: dinInst};
      full  <= 1'b1;
    end
  end

  assign doutInst = entry.inst;
  assign doutPc   = entry.pc;
endmodule

// File: rtl/if_stage.sv
// mips32 instruction-fetch stage: PC, single-outstanding imem handshake,
// stall buffering and redirect draining; feeds the IF/ID register.
module if_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemAck,
  input  logic [31:0] imemData,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirectPc,
  output logic [31:0] pcOut,
  output logic [31:0] instOut,
  output logic        validOut
);
  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  drainPc;
  logic         xfer;
  logic         bufLoad, bufClear, bufFull;
  logic [31:0]  bufInst, bufPc;

  // DRAIN keeps presenting the abandoned address while pc already holds the target.
  assign imemReq  = (state == REQ) || (state == DRAIN);
  assign imemAddr = (state == DRAIN) ? drainPc : pc;
  assign xfer     = imemReq && imemAck;

  assign bufLoad  = !redirect && (state == REQ) && xfer && stall;
  assign bufClear = redirect || ((state == HOLD) && !stall);

  if_fetch_buffer u_buf (
    .clk      (clk),
    .rst      (rst),
    .load     (bufLoad),
    .clear    (bufClear),
    .dinInst  (imemData),
    .dinPc    (next_pc(pc)),
    .doutInst (bufInst),
    .doutPc   (bufPc),
    .full     (bufFull)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      drainPc  <= RESET_PC;
      pcOut    <= 32'h0;
      instOut  <= NOP;
      validOut <= 1'b0;
    end else if (redirect) begin
      validOut <= 1'b0;
      pc       <= redirectPc;
      if (imemReq && !imemAck) begin
        state <= DRAIN;
        if (state == REQ) drainPc <= pc;
      end else begin
        state <= REQ;
      end
    end else begin
      case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (xfer) begin
            pc <= next_pc(pc);
            if (stall) begin
              state <= HOLD;
            end else begin
              instOut  <= imemData;
              pcOut    <= next_pc(pc);
              validOut <= 1'b1;
            end
          end else if (!stall) begin
            validOut <= 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            instOut  <= bufInst;
            pcOut    <= bufPc;
            validOut <= bufFull;
            state    <= REQ;
          end
        end
        DRAIN: begin
          validOut <= 1'b0;
          if (imemAck) state <= REQ;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_if_stage.sv
// Directed + random bench for if_stage against a queue-based fetch model.
module tb_if_stage;
  import mips_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, imemAck, stall, redirect;
  logic [31:0] imemData, redirectPc;
  logic        imemReq, validOut;
  logic [31:0] imemAddr, pcOut, instOut;

  logic        rst1, ack1;
  logic [31:0] data1;
  logic        req1, valid1;
  logic [31:0] addr1, pcOut1, inst1;

  int total = 0;
  int bad   = 0;

  if_stage dut (
    .clk(clk), .rst(rst), .imemReq(imemReq), .imemAddr(imemAddr),
    .imemAck(imemAck), .imemData(imemData), .stall(stall),
    .redirect(redirect), .redirectPc(redirectPc),
    .pcOut(pcOut), .instOut(instOut), .validOut(validOut)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst1), .imemReq(req1), .imemAddr(addr1),
    .imemAck(ack1), .imemData(data1), .stall(1'b0),
    .redirect(1'b0), .redirectPc(32'h0),
    .pcOut(pcOut1), .instOut(inst1), .validOut(valid1)
  );

  // Model: a fetch is "starting" for one cycle after reset, "dropping" while an
  // abandoned request is still outstanding, and parked while m_buf holds a word.
  logic [31:0]  m_pc, m_out_pc, m_out_inst, m_drop_addr;
  logic         m_valid, m_start, m_drop;
  fetch_entry_t m_buf[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    fetch_entry_t e;
    bit req;
    req = !m_start && (m_buf.size() == 0);
    if (rst) begin
      m_start = 1; m_pc = 32'h0; m_out_pc = 32'h0; m_out_inst = 32'h0;
      m_valid = 0; m_drop = 0; m_drop_addr = 32'h0; m_buf.delete();
    end else if (redirect) begin
      m_valid = 0;
      m_buf.delete();
      if (req && !imemAck) begin
        if (!m_drop) m_drop_addr = m_pc;
        m_drop = 1;
      end else begin
        m_drop = 0;
      end
      m_pc = redirectPc;
      m_start = 0;
    end else if (m_start) begin
      m_start = 0;
    end else if (m_drop) begin
      m_valid = 0;
      if (imemAck) m_drop = 0;
    end else if (m_buf.size() != 0) begin
      if (!stall) begin
        e = m_buf.pop_front();
        m_out_pc = e.pc; m_out_inst = e.inst; m_valid = 1;
      end
    end else if (imemAck) begin
      if (stall) m_buf.push_back('{pc: m_pc + 32'd4, inst: imemData});
      else begin
        m_out_pc = m_pc + 32'd4; m_out_inst = imemData; m_valid = 1;
      end
      m_pc = m_pc + 32'd4;
    end else if (!stall) begin
      m_valid = 0;
    end
  endtask

  task automatic tick();
    bit exp_req;
    @(posedge clk);
    model_step();
    #1;
    exp_req = !m_start && (m_buf.size() == 0);
    chk("m_req", {31'b0, imemReq}, {31'b0, exp_req});
    if (exp_req) chk("m_addr", imemAddr, m_drop ? m_drop_addr : m_pc);
    chk("m_valid", {31'b0, validOut}, {31'b0, m_valid});
    chk("m_pcOut", pcOut, m_out_pc);
    chk("m_instOut", instOut, m_out_inst);
  endtask

  initial begin
    rst = 1; imemAck = 0; imemData = 32'h0; stall = 0; redirect = 0; redirectPc = 32'h0;
    rst1 = 1; ack1 = 0; data1 = 32'h0;

    tick();
    chk("rst_req", {31'b0, imemReq}, 32'd0);
    chk("rst_valid", {31'b0, validOut}, 32'd0);
    chk("rst_pcOut", pcOut, 32'h0);
    chk("rst_inst", instOut, NOP);

    rst = 0; tick();
    chk("first_req", {31'b0, imemReq}, 32'd1);
    chk("first_addr", imemAddr, 32'h0);

    // zero-wait memory
    imemAck = 1; imemData = 32'h2008_0001; tick();
    chk("zw_pc0", pcOut, 32'h4); chk("zw_inst0", instOut, 32'h2008_0001);
    chk("zw_valid0", {31'b0, validOut}, 32'd1); chk("zw_addr1", imemAddr, 32'h4);
    imemData = 32'h2009_0002; tick();
    chk("zw_pc1", pcOut, 32'h8); chk("zw_inst1", instOut, 32'h2009_0002);

    // three wait states
    imemAck = 0;
    repeat (3) begin
      tick();
      chk("wait_req", {31'b0, imemReq}, 32'd1); chk("wait_addr", imemAddr, 32'h8);
      chk("wait_bubble", {31'b0, validOut}, 32'd0);
    end
    imemAck = 1; imemData = 32'h1111_0008; tick();
    chk("wait_pc", pcOut, 32'hC); chk("wait_valid", {31'b0, validOut}, 32'd1);
    imemData = 32'h2222_000C; tick();

    // stall while fetch of 0x10 completes
    stall = 1; imemData = 32'h3333_0010; tick();
    chk("hold_req", {31'b0, imemReq}, 32'd0); chk("hold_pc", pcOut, 32'h10);
    chk("hold_inst", instOut, 32'h2222_000C);
    imemAck = 0; tick();
    chk("hold2_req", {31'b0, imemReq}, 32'd0); chk("hold2_pc", pcOut, 32'h10);
    stall = 0; tick();
    chk("rel_inst", instOut, 32'h3333_0010); chk("rel_pc", pcOut, 32'h14);
    chk("rel_valid", {31'b0, validOut}, 32'd1); chk("rel_addr", imemAddr, 32'h14);

    // redirect while 0x20 is outstanding
    imemAck = 1; imemData = 32'h4444_0000; repeat (3) tick();
    imemAck = 0; tick();
    chk("pre_redir_addr", imemAddr, 32'h20);
    redirect = 1; redirectPc = 32'h400; tick();
    chk("drain_req", {31'b0, imemReq}, 32'd1); chk("drain_addr", imemAddr, 32'h20);
    chk("drain_valid", {31'b0, validOut}, 32'd0);
    redirect = 0; tick();
    chk("drain2_addr", imemAddr, 32'h20);
    imemAck = 1; imemData = 32'hDEAD_0020; tick();
    chk("post_drain_addr", imemAddr, 32'h400); chk("post_drain_valid", {31'b0, validOut}, 32'd0);
    imemData = 32'h5555_0400; tick();
    chk("redir_pc", pcOut, 32'h404); chk("redir_inst", instOut, 32'h5555_0400);

    // redirect + stall together while holding
    stall = 1; imemData = 32'h6666_0404; tick();
    chk("hold3_req", {31'b0, imemReq}, 32'd0);
    imemAck = 0; redirect = 1; redirectPc = 32'h800; tick();
    chk("hr_valid", {31'b0, validOut}, 32'd0); chk("hr_req", {31'b0, imemReq}, 32'd1);
    chk("hr_addr", imemAddr, 32'h800);
    redirect = 0; stall = 0; imemAck = 1; imemData = 32'h7777_0800; tick();
    chk("hr_pc", pcOut, 32'h804); chk("hr_inst", instOut, 32'h7777_0800);

    // reset mid-request, then a late ack
    imemAck = 0; tick();
    rst = 1; tick();
    chk("mid_rst_req", {31'b0, imemReq}, 32'd0); chk("mid_rst_valid", {31'b0, validOut}, 32'd0);
    chk("mid_rst_pc", pcOut, 32'h0); chk("mid_rst_inst", instOut, 32'h0);
    rst = 0; imemAck = 1; tick();
    chk("late_ack_valid", {31'b0, validOut}, 32'd0); chk("late_ack_addr", imemAddr, 32'h0);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      imemAck    = ($urandom_range(0, 3) != 0);
      imemData   = $urandom;
      stall      = ($urandom_range(0, 4) == 0);
      redirect   = ($urandom_range(0, 15) == 0);
      redirectPc = $urandom & 32'hFFFF_FFFC;
      rst        = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 0; imemAck = 0; stall = 0; redirect = 0;

    // PC wrap on the second instance
    tick();
    rst1 = 0; tick();
    chk("wrap_addr0", addr1, 32'hFFFF_FFFC); chk("wrap_req", {31'b0, req1}, 32'd1);
    ack1 = 1; data1 = 32'hAAAA_0001; tick();
    chk("wrap_pcOut", pcOut1, 32'h0); chk("wrap_valid", {31'b0, valid1}, 32'd1);
    chk("wrap_addr1", addr1, 32'h0); chk("wrap_inst", inst1, 32'hAAAA_0001);
    ack1 = 0; tick();
    chk("wrap_wait_valid", {31'b0, valid1}, 32'd0);
    rst1 = 1; tick();
    chk("wrap_rst_req", {31'b0, req1}, 32'd0); chk("wrap_rst_valid", {31'b0, valid1}, 32'd0);
    chk("wrap_rst_pc", pcOut1, 32'h0); chk("wrap_rst_inst", inst1, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
